// File: rtl/alarm_clock_pkg.sv
// Shared types, write-port decode, 7-segment table and BCD helpers for the alarm clock.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package alarm_clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2
    } alarm_state_e;

    localparam logic [1:0] SEL_TIME  = 2'd0;
    localparam logic [1:0] SEL_ALARM = 2'd1;
    localparam logic [1:0] SEL_CTRL  = 2'd2;
    localparam logic [1:0] SEL_RSVD  = 2'd3;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low gfedcba with dp (bit7) off; entry i decodes digit i.
    localparam logic [9:0][7:0] SEG_TABLE = {
        8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
        8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic bcd_time_valid(input logic [23:0] t);
        return (t[23:16] <= 8'h23) && (t[19:16] <= 4'd9) &&
               (t[15:12] <= 4'd5)  && (t[11:8]  <= 4'd9) &&
               (t[7:4]   <= 4'd5)  && (t[3:0]   <= 4'd9);
    endfunction

    function automatic logic [23:0] bcd_time_inc(input logic [23:0] t);
        logic [23:0] n;
        n = t;
        if (t[3:0] != 4'd9) begin
            n[3:0] = t[3:0] + 4'd1;
        end else begin
            n[3:0] = 4'd0;
            if (t[7:4] != 4'd5) begin
                n[7:4] = t[7:4] + 4'd1;
            end else begin
                n[7:4] = 4'd0;
                if (t[11:8] != 4'd9) begin
                    n[11:8] = t[11:8] + 4'd1;
                end else begin
                    n[11:8] = 4'd0;
                    if (t[15:12] != 4'd5) begin
                        n[15:12] = t[15:12] + 4'd1;
                    end else begin
                        n[15:12] = 4'd0;
                        if (t[23:16] == 8'h23) begin
                            n[23:16] = 8'h00;
                        end else if (t[19:16] == 4'd9) begin
                            n[19:16] = 4'd0;
                            n[23:20] = t[23:20] + 4'd1;
                        end else begin
                            n[19:16] = t[19:16] + 4'd1;
                        end
                    end
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-low 7-segment pattern with decimal point control.
// Latency: combinational.
// Backpressure: none.
module bcd_to_seg7
    import alarm_clock_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       dp,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (digit <= 4'd9) begin
            seg = SEG_TABLE[digit];
        end
        if (dp) begin
            seg[7] = 1'b0;
        end
    end

endmodule

// File: rtl/alarm_clock_ctrl.sv
// BCD timekeeper, alarm compare, ring/snooze FSM, button debounce, 7-seg and LED drive.
// Latency: writes land next cycle; segments/LEDs/irq are registered one cycle after the state they show.
// Backpressure: none; every write is accepted or rejected in one cycle (wr_err).
module alarm_clock_ctrl
    import alarm_clock_pkg::*;
#(
    parameter int CLK_HZ           = 50000000,
    parameter int DEBOUNCE_CYCLES  = 1000000,
    parameter int SNOOZE_SEC       = 300,
    parameter int RING_TIMEOUT_SEC = 60
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        button_n,
    input  logic        wr_en,
    input  logic [1:0]  wr_sel,
    input  logic [23:0] wr_data,
    output logic        wr_err,
    output logic [23:0] time_bcd,
    output logic        btn_pulse,
    output logic        alarm_irq,
    output logic [7:0]  segment1,
    output logic [7:0]  segment2,
    output logic [7:0]  segment3,
    output logic [7:0]  segment4,
    output logic [7:0]  segment5,
    output logic [7:0]  segment6,
    output logic [9:0]  leds
);

    localparam int PW  = $clog2(CLK_HZ);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW  = $clog2(RING_TIMEOUT_SEC + 1);
    localparam int SW  = $clog2(SNOOZE_SEC + 1);

    localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0]  PRESC_HALF = PW'(CLK_HZ / 2);
    localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);

    logic [PW-1:0]  presc;
    logic [23:0]    time_q;
    logic [15:0]    alarm_q;
    logic           alarm_en_q;
    alarm_state_e   state_q;
    alarm_state_e   state_nxt;
    logic [RW-1:0]  ring_cnt;
    logic [SW-1:0]  snz_cnt;

    logic           btn_s1, btn_s2, btn_db;
    logic [DBW-1:0] db_cnt;

    logic           sec_tick, half, tick_inc, match;
    logic           wr_time, wr_alarm, wr_ctrl;
    logic           time_valid, alarm_valid, time_ok;
    logic           alarm_en_nxt, ack, disable_wr;
    logic [23:0]    t_inc;

    assign sec_tick    = (presc == PRESC_LAST);
    assign half        = (presc < PRESC_HALF);
    assign wr_time     = wr_en && (wr_sel == SEL_TIME);
    assign wr_alarm    = wr_en && (wr_sel == SEL_ALARM);
    assign wr_ctrl     = wr_en && (wr_sel == SEL_CTRL);
    assign time_valid  = bcd_time_valid(wr_data);
    assign alarm_valid = bcd_time_valid({wr_data[23:8], 8'h00});
    assign time_ok     = wr_time && time_valid;
    assign tick_inc    = sec_tick && !time_ok;
    assign t_inc       = bcd_time_inc(time_q);
    assign ack         = wr_ctrl && wr_data[1];
    assign disable_wr  = wr_ctrl && !wr_data[0];
    assign alarm_en_nxt = wr_ctrl ? wr_data[0] : alarm_en_q;
    assign time_bcd    = time_q;

    // Only a real seconds roll-over can trigger; a loaded time never does.
    assign match = tick_inc && (t_inc[7:0] == 8'h00) && (t_inc[23:8] == alarm_q) &&
                   alarm_en_q && (state_q == ST_IDLE);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            presc      <= '0;
            time_q     <= '0;
            alarm_q    <= '0;
            alarm_en_q <= 1'b0;
            wr_err     <= 1'b0;
        end else begin
            if (time_ok) begin
                time_q <= wr_data;
                presc  <= '0;
            end else begin
                presc <= sec_tick ? '0 : presc + 1'b1;
                if (sec_tick) begin
                    time_q <= t_inc;
                end
            end
            if (wr_alarm && alarm_valid) begin
                alarm_q <= wr_data[23:8];
            end
            if (wr_ctrl) begin
                alarm_en_q <= wr_data[0];
            end
            wr_err <= (wr_time && !time_valid) || (wr_alarm && !alarm_valid);
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            btn_s1    <= 1'b1;
            btn_s2    <= 1'b1;
            btn_db    <= 1'b1;
            db_cnt    <= '0;
            btn_pulse <= 1'b0;
        end else begin
            btn_s1    <= button_n;
            btn_s2    <= btn_s1;
            btn_pulse <= 1'b0;
            if (btn_s2 == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt    <= '0;
                btn_db    <= btn_s2;
                btn_pulse <= btn_db;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        if (disable_wr) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (match) state_nxt = ST_RINGING;
                end
                ST_RINGING: begin
                    if (ack)                                   state_nxt = ST_IDLE;
                    else if (tick_inc && ring_cnt <= RW'(1))   state_nxt = ST_IDLE;
                    else if (btn_pulse)                        state_nxt = ST_SNOOZE;
                end
                ST_SNOOZE: begin
                    if (ack)                                   state_nxt = ST_IDLE;
                    else if (tick_inc && snz_cnt <= SW'(1))    state_nxt = ST_RINGING;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q   <= ST_IDLE;
            ring_cnt  <= '0;
            snz_cnt   <= '0;
            alarm_irq <= 1'b0;
            leds      <= '0;
        end else begin
            state_q   <= state_nxt;
            alarm_irq <= (state_nxt == ST_RINGING);
            if (state_nxt == ST_RINGING && state_q != ST_RINGING) begin
                ring_cnt <= RW'(RING_TIMEOUT_SEC);
            end else if (state_q == ST_RINGING && tick_inc) begin
                ring_cnt <= ring_cnt - 1'b1;
            end
            if (state_nxt == ST_SNOOZE && state_q != ST_SNOOZE) begin
                snz_cnt <= SW'(SNOOZE_SEC);
            end else if (state_q == ST_SNOOZE && tick_inc) begin
                snz_cnt <= snz_cnt - 1'b1;
            end
            case (state_nxt)
                ST_RINGING: leds <= {10{half}};
                ST_SNOOZE:  leds <= {1'b1, 8'h00, alarm_en_nxt};
                default:    leds <= {9'h000, alarm_en_nxt};
            endcase
        end
    end

    logic [7:0] seg_nxt [6];
    logic [7:0] seg_q   [6];

    for (genvar i = 0; i < 6; i++) begin : g_dec
        bcd_to_seg7 u_dec (
            .digit (time_q[4*i +: 4]),
            .dp    ((i == 2 || i == 4) ? half : 1'b0),
            .seg   (seg_nxt[i])
        );
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < 6; i++) begin
                seg_q[i] <= (i == 2 || i == 4) ? 8'h40 : 8'hC0;
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                seg_q[i] <= seg_nxt[i];
            end
        end
    end

    assign segment1 = seg_q[0];
    assign segment2 = seg_q[1];
    assign segment3 = seg_q[2];
    assign segment4 = seg_q[3];
    assign segment5 = seg_q[4];
    assign segment6 = seg_q[5];

endmodule
